// File: rtl/bullet_damage_engine_pkg.sv
// Shared game definitions: bullet colour codes, damage-engine FSM encoding
// and HP defaults also used by the VGA state formatter.
package bullet_damage_engine_pkg;

  localparam logic [2:0] COL_WHITE  = 3'd0;
  localparam logic [2:0] COL_BLUE   = 3'd1;
  localparam logic [2:0] COL_ORANGE = 3'd2;
  localparam logic [2:0] COL_GREEN  = 3'd3;

  localparam int DEF_HP_MAX   = 100;
  localparam int DEF_DMG_AMT  = 5;
  localparam int DEF_HEAL_AMT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

endpackage

// File: rtl/bullet_damage_engine_aabb_overlap.sv
// Combinational axis-aligned box overlap test between the player square
// and one bullet rectangle; edge sums carry an extra bit so nothing wraps.
module aabb_overlap #(
  parameter int POS_W = 8
) (
  input  logic [POS_W-1:0] px_i,
  input  logic [POS_W-1:0] py_i,
  input  logic [POS_W-1:0] ps_i,
  input  logic [POS_W-1:0] bx_i,
  input  logic [POS_W-1:0] by_i,
  input  logic [POS_W-1:0] bw_i,
  input  logic [POS_W-1:0] bh_i,
  output logic             hit_o
);

  logic [POS_W:0] p_x_end, p_y_end, b_x_end, b_y_end;

  assign p_x_end = {1'b0, px_i} + {1'b0, ps_i};
  assign p_y_end = {1'b0, py_i} + {1'b0, ps_i};
  assign b_x_end = {1'b0, bx_i} + {1'b0, bw_i};
  assign b_y_end = {1'b0, by_i} + {1'b0, bh_i};

  // Strict compares: boxes that only share an edge do not collide.
  assign hit_o = ({1'b0, px_i} < b_x_end) && ({1'b0, bx_i} < p_x_end) &&
                 ({1'b0, py_i} < b_y_end) && ({1'b0, by_i} < p_y_end);

endmodule

// File: rtl/bullet_damage_engine.sv
// Per-tick scan of all bullet channels against the player through one shared
// overlap checker; resolves the first qualifying hit into damage or heal.
module bullet_damage_engine
  import bullet_damage_engine_pkg::*;
#(
  parameter int N_BULLETS = 4,
  parameter int POS_W     = 8,
  parameter int HP_W      = 8,
  parameter int HP_MAX    = DEF_HP_MAX,
  parameter int DMG_AMT   = DEF_DMG_AMT,
  parameter int HEAL_AMT  = DEF_HEAL_AMT,
  parameter int IFRAMES   = 5,
  localparam int IDX_W    = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         restart,
  input  logic [POS_W-1:0]             player_x,
  input  logic [POS_W-1:0]             player_y,
  input  logic [POS_W-1:0]             player_size,
  input  logic                         player_moving,
  input  logic [N_BULLETS*2*POS_W-1:0] bullet_pos,
  input  logic [N_BULLETS*2*POS_W-1:0] bullet_size,
  input  logic [N_BULLETS*3-1:0]       bullet_color,
  input  logic [N_BULLETS-1:0]         bullet_active,
  output logic [HP_W-1:0]              hp,
  output logic                         is_death,
  output logic                         invuln,
  output logic                         hit_valid,
  output logic [IDX_W-1:0]             hit_index,
  output logic                         busy,
  output state_t                       dbg_state
);

  localparam int CNT_W = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, found_idx_q, found_idx_d, hit_index_q, hit_index_d;
  logic               found_q, found_d, found_heal_q, found_heal_d;
  logic [POS_W-1:0]   px_q, px_d, py_q, py_d, ps_q, ps_d;
  logic               mov_q, mov_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic               dead_q, dead_d, invuln_q, invuln_d;
  logic               hit_valid_q, hit_valid_d, busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2*POS_W-1:0] cur_pos, cur_size;
  logic [2:0]         cur_col;
  logic               cur_act, overlap, dmg_type, heal_type, chan_hit;
  logic [HP_W:0]      heal_sum;

  // Bullet inputs are read live for the channel under scan.
  assign cur_pos  = bullet_pos[int'(idx_q)*2*POS_W +: 2*POS_W];
  assign cur_size = bullet_size[int'(idx_q)*2*POS_W +: 2*POS_W];
  assign cur_col  = bullet_color[int'(idx_q)*3 +: 3];
  assign cur_act  = bullet_active[idx_q];

  aabb_overlap #(.POS_W(POS_W)) u_overlap (
    .px_i  (px_q),
    .py_i  (py_q),
    .ps_i  (ps_q),
    .bx_i  (cur_pos[2*POS_W-1:POS_W]),
    .by_i  (cur_pos[POS_W-1:0]),
    .bw_i  (cur_size[2*POS_W-1:POS_W]),
    .bh_i  (cur_size[POS_W-1:0]),
    .hit_o (overlap)
  );

  always_comb begin
    dmg_type  = 1'b0;
    heal_type = 1'b0;
    case (cur_col)
      COL_WHITE:  dmg_type  = 1'b1;
      COL_BLUE:   dmg_type  = mov_q;
      COL_ORANGE: dmg_type  = !mov_q;
      COL_GREEN:  heal_type = 1'b1;
      default:    ;
    endcase
  end

  assign chan_hit = cur_act && overlap && (heal_type || (dmg_type && (cnt_q == '0)));
  assign heal_sum = {1'b0, hp_q} + (HP_W+1)'(HEAL_AMT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      found_q      <= 1'b0;
      found_idx_q  <= '0;
      found_heal_q <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      ps_q         <= '0;
      mov_q        <= 1'b0;
      hp_q         <= HP_W'(HP_MAX);
      dead_q       <= 1'b0;
      cnt_q        <= '0;
      invuln_q     <= 1'b0;
      hit_valid_q  <= 1'b0;
      hit_index_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      found_q      <= found_d;
      found_idx_q  <= found_idx_d;
      found_heal_q <= found_heal_d;
      px_q         <= px_d;
      py_q         <= py_d;
      ps_q         <= ps_d;
      mov_q        <= mov_d;
      hp_q         <= hp_d;
      dead_q       <= dead_d;
      cnt_q        <= cnt_d;
      invuln_q     <= invuln_d;
      hit_valid_q  <= hit_valid_d;
      hit_index_q  <= hit_index_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick && !dead_q) state_d = ST_SCAN;
      ST_SCAN:  if (idx_q == IDX_W'(N_BULLETS - 1)) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  always_comb begin
    idx_d        = idx_q;
    found_d      = found_q;
    found_idx_d  = found_idx_q;
    found_heal_d = found_heal_q;
    px_d         = px_q;
    py_d         = py_q;
    ps_d         = ps_q;
    mov_d        = mov_q;
    hp_d         = hp_q;
    dead_d       = dead_q;
    cnt_d        = cnt_q;
    hit_valid_d  = 1'b0;
    hit_index_d  = hit_index_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && !dead_q) begin
          px_d    = player_x;
          py_d    = player_y;
          ps_d    = player_size;
          mov_d   = player_moving;
          found_d = 1'b0;
          idx_d   = '0;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SCAN: begin
        // Lowest index wins; later channels are still visited.
        if (!found_q && chan_hit) begin
          found_d      = 1'b1;
          found_idx_d  = idx_q;
          found_heal_d = heal_type;
        end
        idx_d = idx_q + 1'b1;
      end
      ST_APPLY: begin
        if (found_q) begin
          hit_valid_d = 1'b1;
          hit_index_d = found_idx_q;
          if (found_heal_q) begin
            hp_d = (heal_sum > (HP_W+1)'(HP_MAX)) ? HP_W'(HP_MAX) : heal_sum[HP_W-1:0];
          end else begin
            hp_d  = (hp_q <= HP_W'(DMG_AMT)) ? '0 : hp_q - HP_W'(DMG_AMT);
            cnt_d = CNT_W'(IFRAMES);
            if (hp_q <= HP_W'(DMG_AMT)) dead_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      hp_d        = HP_W'(HP_MAX);
      dead_d      = 1'b0;
      cnt_d       = '0;
      found_d     = 1'b0;
      hit_valid_d = 1'b0;
    end
  end

  assign busy_d   = (state_d != ST_IDLE);
  assign invuln_d = (cnt_d != '0);

  assign hp        = hp_q;
  assign is_death  = dead_q;
  assign invuln    = invuln_q;
  assign hit_valid = hit_valid_q;
  assign hit_index = hit_index_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
